// File: rtl/player1_render_pkg.sv
// -----------------------------------------------------------------------------
// player1_render_pkg
// Shared constants and types for the player-1 sprite render stage.
//   - Sprite geometry (128x128) and ROM address split (row bits | column bits)
//   - Default ROM latency and hit-flash duration
//   - Transparent key colour and the 12-bit RGB 4:4:4 pixel type
//   - Visible screen size (640x480)
//   - mirror_col: horizontal mirroring of a sprite column index
// -----------------------------------------------------------------------------
package player1_render_pkg;

    localparam int SPRITE_W         = 128;
    localparam int SPRITE_H         = 128;
    localparam int COL_W            = $clog2(SPRITE_W);
    localparam int ROW_W            = $clog2(SPRITE_H);
    localparam int ADDR_W           = COL_W + ROW_W;
    localparam int SPRITE_LAT_DEF   = 2;
    localparam int FLASH_FRAMES_DEF = 60;
    localparam int SCREEN_W         = 640;
    localparam int SCREEN_H         = 480;
    localparam int RGB_W            = 12;

    typedef logic [RGB_W-1:0]  rgb_t;
    typedef logic [ADDR_W-1:0] sprite_addr_t;

    localparam rgb_t TRANSPARENT = 12'hF0F;

    // Column index as fetched from the ROM: mirrored when the player faces left.
    function automatic logic [COL_W-1:0] mirror_col(input logic [COL_W-1:0] dx,
                                                    input logic            face_left);
        logic [COL_W-1:0] col;
        if (face_left) begin
            col = COL_W'(SPRITE_W - 1) - dx;
        end else begin
            col = dx;
        end
        return col;
    endfunction

endpackage

// File: rtl/player1_render_if.sv
// -----------------------------------------------------------------------------
// player1_render_if
// Sprite-ROM bus between the render stage and the player-1 sprite selector.
//   sprite_addr  : 14-bit registered ROM address (render -> selector)
//   sprite_pixel : 12-bit RGB returned SPRITE_LAT clocks later (selector -> render)
// Modports: master = render stage, slave = sprite selector / ROM.
// -----------------------------------------------------------------------------
interface player1_render_if;
    import player1_render_pkg::*;

    sprite_addr_t sprite_addr;
    rgb_t         sprite_pixel;

    modport master (output sprite_addr, input sprite_pixel);
    modport slave  (input sprite_addr, output sprite_pixel);

endinterface

// File: rtl/pipe_delay.sv
// -----------------------------------------------------------------------------
// pipe_delay
// Fixed-depth register delay line with synchronous active-high reset.
//   clk   : clock
//   rst   : synchronous reset, clears every stage
//   d     : WIDTH-bit input
//   q     : d delayed by DEPTH clocks (DEPTH >= 1)
// -----------------------------------------------------------------------------
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift register: stage 0 takes d, each later stage takes its predecessor.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/player1_render.sv
// -----------------------------------------------------------------------------
// player1_render
// Generates the player-1 sprite ROM address from the scan position and the
// frame-latched player position, then composites the returned pixel over the
// background. Latency hcount -> rgb_out is SPRITE_LAT + 2 clocks, no stalls.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   hcount, vcount    : scan column/row
//   video_on          : visible region flag, aligned with hcount/vcount
//   frame_start       : one-clock pulse before the first visible pixel
//   bg_rgb            : background colour, aligned with hcount/vcount
//   pos_x, pos_y      : live sprite top-left position
//   facing_left       : 1 = mirror horizontally
//   hit               : one-clock damage pulse, starts the blink period
//   sprite_bus        : ROM bus (sprite_addr out, sprite_pixel in)
//   rgb_out           : composited colour, 0 when blanked
//   opaque_out        : visible opaque sprite pixel drawn this clock
//   video_on_out      : video_on aligned with rgb_out
// -----------------------------------------------------------------------------
module player1_render
    import player1_render_pkg::*;
#(
    parameter int SPRITE_LAT   = SPRITE_LAT_DEF,
    parameter int FLASH_FRAMES = FLASH_FRAMES_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [9:0]               hcount,
    input  logic [9:0]               vcount,
    input  logic                     video_on,
    input  logic                     frame_start,
    input  rgb_t                     bg_rgb,
    input  logic [9:0]               pos_x,
    input  logic [9:0]               pos_y,
    input  logic                     facing_left,
    input  logic                     hit,
    player1_render_if.master         sprite_bus,
    output rgb_t                     rgb_out,
    output logic                     opaque_out,
    output logic                     video_on_out
);

    localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);
    localparam int DLY_W   = 2 + RGB_W;

    // Frame-latched position/facing and blink state
    logic [9:0]         lx_r;
    logic [9:0]         ly_r;
    logic               lface_r;
    logic [FLASH_W-1:0] flash_cnt_r;
    logic [FLASH_W-1:0] flash_next_s;
    logic               hidden_r;

    // Stage 1: address generation
    logic [10:0]        dx_s;
    logic [10:0]        dy_s;
    logic               in_box_s;
    logic [COL_W-1:0]   col_s;
    sprite_addr_t       addr_s;
    sprite_addr_t       sprite_addr_r;
    logic               in_box_r;
    logic               video_on_r;
    rgb_t               bg_r;

    // Alignment line and composite stage
    logic [DLY_W-1:0]   dly_in_s;
    logic [DLY_W-1:0]   dly_out_s;
    logic               in_box_d_s;
    logic               video_on_d_s;
    rgb_t               bg_d_s;
    logic               show_s;
    rgb_t               rgb_next_s;
    rgb_t               rgb_out_r;
    logic               opaque_out_r;
    logic               video_on_out_r;

    // Flash counter next value: a hit reload takes priority over the per-frame decrement.
    always_comb begin
        flash_next_s = flash_cnt_r;
        if (hit) begin
            flash_next_s = FLASH_W'(FLASH_FRAMES);
        end else if (frame_start && (flash_cnt_r != '0)) begin
            flash_next_s = flash_cnt_r - FLASH_W'(1);
        end else begin
            flash_next_s = flash_cnt_r;
        end
    end

    // Per-frame state: position/facing and the hidden flag only move on frame_start
    // so a whole frame renders from one consistent snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            lx_r        <= 10'd0;
            ly_r        <= 10'd0;
            lface_r     <= 1'b0;
            flash_cnt_r <= '0;
            hidden_r    <= 1'b0;
        end else begin
            flash_cnt_r <= flash_next_s;
            if (frame_start) begin
                lx_r     <= pos_x;
                ly_r     <= pos_y;
                lface_r  <= facing_left;
                // Uses the post-update count so a coincident hit blanks this frame.
                hidden_r <= (flash_next_s != '0) && flash_next_s[2];
            end
        end
    end

    // Box test and ROM address. The explicit hcount>=lx / vcount>=ly terms stop a
    // wrapped (negative) difference from aliasing into the box.
    always_comb begin
        dx_s     = {1'b0, hcount} - {1'b0, lx_r};
        dy_s     = {1'b0, vcount} - {1'b0, ly_r};
        in_box_s = (hcount >= lx_r) && (dx_s < 11'(SPRITE_W)) &&
                   (vcount >= ly_r) && (dy_s < 11'(SPRITE_H));
        col_s    = mirror_col(dx_s[COL_W-1:0], lface_r);
        // Power-of-two width: row*SPRITE_W + col is a plain concatenation.
        if (in_box_s) begin
            addr_s = {dy_s[ROW_W-1:0], col_s};
        end else begin
            addr_s = '0;
        end
    end

    // Stage 1 registers: ROM address plus the side-band that must follow the pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            sprite_addr_r <= '0;
            in_box_r      <= 1'b0;
            video_on_r    <= 1'b0;
            bg_r          <= '0;
        end else begin
            sprite_addr_r <= addr_s;
            in_box_r      <= in_box_s;
            video_on_r    <= video_on;
            bg_r          <= bg_rgb;
        end
    end

    assign sprite_bus.sprite_addr = sprite_addr_r;
    assign dly_in_s               = {in_box_r, video_on_r, bg_r};

    pipe_delay #(
        .WIDTH (DLY_W),
        .DEPTH (SPRITE_LAT)
    ) u_align (
        .clk (clk),
        .rst (rst),
        .d   (dly_in_s),
        .q   (dly_out_s)
    );

    assign {in_box_d_s, video_on_d_s, bg_d_s} = dly_out_s;

    // Composite: key colour and blink-hidden frames fall through to the background.
    always_comb begin
        show_s = in_box_d_s && !hidden_r && (sprite_bus.sprite_pixel != TRANSPARENT);
        if (!video_on_d_s) begin
            rgb_next_s = '0;
        end else if (show_s) begin
            rgb_next_s = sprite_bus.sprite_pixel;
        end else begin
            rgb_next_s = bg_d_s;
        end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out_r      <= '0;
            opaque_out_r   <= 1'b0;
            video_on_out_r <= 1'b0;
        end else begin
            rgb_out_r      <= rgb_next_s;
            opaque_out_r   <= show_s && video_on_d_s;
            video_on_out_r <= video_on_d_s;
        end
    end

    assign rgb_out      = rgb_out_r;
    assign opaque_out   = opaque_out_r;
    assign video_on_out = video_on_out_r;

endmodule

// File: tb/tb_player1_render.sv
// -----------------------------------------------------------------------------
// tb_player1_render
// Drives player1_render with directed and randomized scan stimulus, models a
// 2-clock sprite ROM, and compares every output cycle against a behavioural
// reference computed from sprite geometry, frame latching and blink rules.
// -----------------------------------------------------------------------------
module tb_player1_render;
    import player1_render_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] hcount, vcount, pos_x, pos_y;
    logic       video_on, frame_start, facing_left, hit;
    rgb_t       bg_rgb, rgb_out;
    logic       opaque_out, video_on_out;

    int checks = 0;
    int errors = 0;

    player1_render_if bus ();

    player1_render dut (
        .clk          (clk),
        .rst          (rst),
        .hcount       (hcount),
        .vcount       (vcount),
        .video_on     (video_on),
        .frame_start  (frame_start),
        .bg_rgb       (bg_rgb),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .facing_left  (facing_left),
        .hit          (hit),
        .sprite_bus   (bus),
        .rgb_out      (rgb_out),
        .opaque_out   (opaque_out),
        .video_on_out (video_on_out)
    );

    always #5 clk = ~clk;

    // Sprite ROM: two registers between address and returned pixel.
    rgb_t rom [16384];
    rgb_t rom_q1;
    always @(posedge clk) begin
        rom_q1           <= rom[bus.sprite_addr];
        bus.sprite_pixel <= rom_q1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    int   m_lx = 0, m_ly = 0, m_cnt = 0;
    bit   m_face = 1'b0, m_hidden = 1'b0;
    int   cyc = 0;
    int   exp_addr [8];
    bit   exp_av   [8];
    int   exp_rgb  [8];
    bit   exp_op   [8];
    bit   exp_von  [8];
    bit   exp_v    [8];

    // Compare outputs of the last edge, then predict from the inputs the next edge samples.
    always @(negedge clk) begin
        int c, idx, dx, dy, col, a;
        bit inb, shw;
        rgb_t px;
        cyc = cyc + 1;
        c = cyc & 7;
        if (exp_av[c]) chk("sprite_addr", int'(bus.sprite_addr), exp_addr[c]);
        if (exp_v[c]) begin
            chk("rgb_out", int'(rgb_out), exp_rgb[c]);
            chk("opaque_out", int'(opaque_out), int'(exp_op[c]));
            chk("video_on_out", int'(video_on_out), int'(exp_von[c]));
        end
        if (rst) begin
            exp_addr[(cyc+1)&7] = 0;
            exp_av[(cyc+1)&7]   = 1'b1;
            for (int j = 1; j <= 4; j++) begin
                idx = (cyc + j) & 7;
                exp_v[idx] = 1'b1; exp_rgb[idx] = 0; exp_op[idx] = 1'b0; exp_von[idx] = 1'b0;
            end
            m_lx = 0; m_ly = 0; m_face = 1'b0; m_cnt = 0; m_hidden = 1'b0;
        end else begin
            dx  = int'(hcount) - m_lx;
            dy  = int'(vcount) - m_ly;
            inb = (dx >= 0) && (dx < SPRITE_W) && (dy >= 0) && (dy < SPRITE_H);
            col = m_face ? (SPRITE_W - 1 - dx) : dx;
            a   = inb ? (dy * SPRITE_W + col) : 0;
            exp_addr[(cyc+1)&7] = a;
            exp_av[(cyc+1)&7]   = 1'b1;
            px  = rom[a];
            shw = inb && !m_hidden && (px != TRANSPARENT);
            idx = (cyc + 4) & 7;
            exp_v[idx]   = 1'b1;
            exp_von[idx] = video_on;
            exp_rgb[idx] = !video_on ? 0 : (shw ? int'(px) : int'(bg_rgb));
            exp_op[idx]  = shw && video_on;
            if (hit) m_cnt = FLASH_FRAMES_DEF;
            else if (frame_start && m_cnt > 0) m_cnt = m_cnt - 1;
            if (frame_start) begin
                m_hidden = (m_cnt != 0) && (((m_cnt / 4) % 2) == 1);
                m_lx = int'(pos_x); m_ly = int'(pos_y); m_face = facing_left;
            end
        end
    end

    task automatic drive(input int h, input int v, input bit von, input int bg,
                         input bit fs, input bit ht);
        hcount = 10'(h); vcount = 10'(v); video_on = von; bg_rgb = 12'(bg);
        frame_start = fs; hit = ht;
        @(posedge clk);
        #1;
    endtask

    task automatic blank();
        drive(0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic frame(input bit ht);
        drive(0, 0, 1'b0, 0, 1'b1, ht);
    endtask

    // Draws the sprite origin pixel (rom[0]) at latched (100,50) over bg 123.
    task automatic draw_check(input string nm, input int er, input bit eo);
        drive(100, 50, 1'b1, 'h123, 1'b0, 1'b0);
        blank(); blank(); blank();
        chk({nm, "_rgb"}, int'(rgb_out), er);
        chk({nm, "_opaque"}, int'(opaque_out), int'(eo));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int h, v;
        for (int i = 0; i < 16384; i++) begin
            rom[i] = ($urandom_range(0, 3) == 0) ? TRANSPARENT : rgb_t'($urandom);
        end
        rom[0] = 12'hABC;
        rom[1] = 12'hF0F;
        rst = 1'b1; pos_x = 10'd0; pos_y = 10'd0; facing_left = 1'b0;
        blank(); blank(); blank();
        chk("reset_addr", int'(bus.sprite_addr), 0);
        chk("reset_rgb", int'(rgb_out), 0);
        chk("reset_opaque", int'(opaque_out), 0);
        chk("reset_von", int'(video_on_out), 0);
        rst = 1'b0;

        // Origin pixel, transparency and latency
        pos_x = 10'd100; pos_y = 10'd50; facing_left = 1'b0;
        frame(1'b0);
        drive(100, 50, 1'b1, 'h123, 1'b0, 1'b0);
        chk("addr_origin", int'(bus.sprite_addr), 0);
        drive(101, 50, 1'b1, 'h123, 1'b0, 1'b0);
        chk("addr_col1", int'(bus.sprite_addr), 1);
        blank();
        chk("latency_not_yet", int'(rgb_out), 0);
        blank();
        chk("pixel_abc_rgb", int'(rgb_out), 'hABC);
        chk("pixel_abc_opaque", int'(opaque_out), 1);
        blank();
        chk("transparent_rgb", int'(rgb_out), 'h123);
        chk("transparent_opaque", int'(opaque_out), 0);

        // Mirroring
        facing_left = 1'b1;
        frame(1'b0);
        drive(100, 51, 1'b1, 'h123, 1'b0, 1'b0);
        chk("mirror_255", int'(bus.sprite_addr), 255);
        drive(100, 50, 1'b1, 'h123, 1'b0, 1'b0);
        chk("mirror_127", int'(bus.sprite_addr), 127);

        // Position latched only at frame_start
        pos_x = 10'd300;
        drive(100, 51, 1'b1, 'h123, 1'b0, 1'b0);
        chk("latch_old_pos", int'(bus.sprite_addr), 255);
        drive(300, 51, 1'b1, 'h123, 1'b0, 1'b0);
        chk("latch_new_not_yet", int'(bus.sprite_addr), 0);
        frame(1'b0);
        drive(300, 51, 1'b1, 'h123, 1'b0, 1'b0);
        chk("latch_new_pos", int'(bus.sprite_addr), 255);
        drive(100, 51, 1'b1, 'h123, 1'b0, 1'b0);
        chk("left_of_box", int'(bus.sprite_addr), 0);

        // Right-edge clipping
        pos_x = 10'd600; pos_y = 10'd50; facing_left = 1'b0;
        frame(1'b0);
        drive(639, 50, 1'b1, 'h123, 1'b0, 1'b0);
        chk("clip_col39", int'(bus.sprite_addr), 39);
        drive(5, 50, 1'b1, 'h123, 1'b0, 1'b0);
        chk("no_wrap", int'(bus.sprite_addr), 0);

        // Hit flash
        pos_x = 10'd100; pos_y = 10'd50;
        frame(1'b0);
        drive(0, 0, 1'b0, 0, 1'b0, 1'b1);
        draw_check("hit_same_frame", 'hABC, 1'b1);
        frame(1'b0);
        draw_check("flash_cnt59", 'hABC, 1'b1);
        frame(1'b0); frame(1'b0); frame(1'b0); frame(1'b0);
        draw_check("flash_cnt55", 'h123, 1'b0);
        frame(1'b1);
        draw_check("hit_with_frame", 'h123, 1'b0);
        for (int f = 0; f < 60; f++) frame(1'b0);
        draw_check("flash_over", 'hABC, 1'b1);

        // Mid-line reset
        drive(100, 50, 1'b1, 'h123, 1'b0, 1'b0);
        drive(101, 50, 1'b1, 'h123, 1'b0, 1'b0);
        drive(100, 50, 1'b1, 'h123, 1'b0, 1'b0);
        drive(100, 50, 1'b1, 'h123, 1'b0, 1'b0);
        chk("pre_rst_rgb", int'(rgb_out), 'hABC);
        rst = 1'b1;
        blank();
        chk("mid_rst_rgb", int'(rgb_out), 0);
        chk("mid_rst_addr", int'(bus.sprite_addr), 0);
        rst = 1'b0;

        // Randomized frames
        for (int f = 0; f < 120; f++) begin
            pos_x = 10'($urandom_range(0, 700));
            pos_y = 10'($urandom_range(0, 500));
            facing_left = 1'($urandom_range(0, 1));
            blank(); blank(); blank();
            frame($urandom_range(0, 9) == 0);
            blank(); blank(); blank();
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 9) == 0) pos_x = 10'($urandom_range(0, 700));
                rst = ($urandom_range(0, 399) == 0);
                h = m_lx - 8 + int'($urandom_range(0, 143));
                v = m_ly - 8 + int'($urandom_range(0, 143));
                if (h < 0) h = 0;
                if (h > 799) h = 799;
                if (v < 0) v = 0;
                if (v > 524) v = 524;
                drive(h, v, (h < SCREEN_W) && (v < SCREEN_H), int'($urandom_range(0, 4095)),
                      1'b0, $urandom_range(0, 299) == 0);
            end
            rst = 1'b0;
        end
        blank(); blank(); blank(); blank(); blank();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
